// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and
// the counter width derived from the operand width.
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  localparam int unsigned DIV_DEFAULT_WIDTH = 32;

  // Bits needed to count 0 .. dw-1 iterations (the iteration count never exceeds dw)
  function automatic int unsigned cnt_width(input int unsigned dw);
    return (dw < 2) ? 1 : $clog2(dw);
  endfunction

  localparam int unsigned DIV_CNT_W = cnt_width(DIV_DEFAULT_WIDTH);

endpackage

// File: rtl/div_step.sv
// One unsigned restoring division step: shift the partial remainder left by
// one bit (pulling in the next dividend bit), trial-subtract the divisor,
// keep the difference when it does not borrow, and shift in the quotient bit.
module div_step #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem_i,
  input  logic [DATA_WIDTH-1:0] quo_i,
  input  logic [DATA_WIDTH-1:0] dvs_i,
  output logic [DATA_WIDTH-1:0] rem_o,
  output logic [DATA_WIDTH-1:0] quo_o
);

  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] trial;

  // Shift, trial subtract, select; borrow out of the MSB means "divisor did not fit"
  always_comb begin
    shifted = {rem_i, quo_i[DATA_WIDTH-1]};
    trial   = shifted - {1'b0, dvs_i};
    if (!trial[DATA_WIDTH]) begin
      rem_o = trial[DATA_WIDTH-1:0];
      quo_o = {quo_i[DATA_WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[DATA_WIDTH-1:0];
      quo_o = {quo_i[DATA_WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider, signed or unsigned, STEPS_PER_CYCLE quotient
// bits per clock. Operates on magnitudes and fixes signs in a final cycle;
// divide-by-zero and signed MIN/-1 overflow complete on the accepting edge.
module div_iter
  import div_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = DIV_DEFAULT_WIDTH,
  parameter int unsigned STEPS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic                  signed_ope,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_by_zero,
  output logic                  overflow
);

  localparam int unsigned   ITER = DATA_WIDTH / STEPS_PER_CYCLE;
  localparam int unsigned   CW   = cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);
  localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  if (DATA_WIDTH < 2) begin : g_chk_width
    $error("div_iter: DATA_WIDTH must be at least 2");
  end
  if (STEPS_PER_CYCLE == 0 || (DATA_WIDTH % STEPS_PER_CYCLE) != 0) begin : g_chk_steps
    $error("div_iter: DATA_WIDTH must be a multiple of STEPS_PER_CYCLE");
  end

  div_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;
  logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
  logic                  qneg_q, qneg_d;
  logic                  rneg_q, rneg_d;
  logic [DATA_WIDTH-1:0] quotient_q, quotient_d;
  logic [DATA_WIDTH-1:0] remainder_q, remainder_d;
  logic                  dbz_q, dbz_d;
  logic                  ovf_q, ovf_d;

  logic                  accept;
  logic                  a_neg, b_neg;
  logic [DATA_WIDTH-1:0] a_mag, b_mag;
  logic                  is_zero, is_ovf;

  logic [DATA_WIDTH-1:0] rem_c [STEPS_PER_CYCLE+1];
  logic [DATA_WIDTH-1:0] quo_c [STEPS_PER_CYCLE+1];

  assign rem_c[0] = rem_q;
  assign quo_c[0] = quo_q;

  for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_step
    div_step #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
      .rem_i(rem_c[g]),
      .quo_i(quo_c[g]),
      .dvs_i(dvs_q),
      .rem_o(rem_c[g+1]),
      .quo_o(quo_c[g+1])
    );
  end

  // Operand decode at the input: signs, magnitudes and the two early-out cases
  always_comb begin
    accept  = (state_q == ST_IDLE) && in_valid && !flush;
    a_neg   = signed_ope & dividend[DATA_WIDTH-1];
    b_neg   = signed_ope & divisor[DATA_WIDTH-1];
    a_mag   = a_neg ? (~dividend + 1'b1) : dividend;
    b_mag   = b_neg ? (~divisor + 1'b1) : divisor;
    is_zero = (divisor == '0);
    is_ovf  = signed_ope && (dividend == MIN_VAL) && (divisor == '1);
  end

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (in_valid) state_d = (is_zero || is_ovf) ? ST_DONE : ST_BUSY;
      ST_BUSY: if (cnt_q == LAST) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  // Datapath next values; result registers load only on the way into DONE
  always_comb begin
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d  = '0;
          rem_d  = '0;
          quo_d  = a_mag;
          dvs_d  = b_mag;
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          if (is_zero) begin
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            ovf_d       = 1'b0;
          end else if (is_ovf) begin
            quotient_d  = MIN_VAL;
            remainder_d = '0;
            dbz_d       = 1'b0;
            ovf_d       = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        rem_d = rem_c[STEPS_PER_CYCLE];
        quo_d = quo_c[STEPS_PER_CYCLE];
        cnt_d = cnt_q + 1'b1;
      end
      ST_FIX: begin
        if (!flush) begin
          quotient_d  = qneg_q ? (~quo_q + 1'b1) : quo_q;
          remainder_d = rneg_q ? (~rem_q + 1'b1) : rem_q;
          dbz_d       = 1'b0;
          ovf_d       = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter at 32 bits, four quotient bits per clock.
module tb_div_iter;

  localparam int unsigned DW   = 32;
  localparam int unsigned S    = 4;
  localparam int unsigned ITER = DW / S;

  logic          clk = 1'b0;
  logic          nrst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [DW-1:0] divisor;
  logic          signed_ope;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [DW-1:0] remainder;
  logic          div_by_zero;
  logic          overflow;

  int errors = 0;
  int checks = 0;
  int lat;

  always #5 clk = ~clk;

  div_iter #(
    .DATA_WIDTH(DW),
    .STEPS_PER_CYCLE(S)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .dividend(dividend),
    .divisor(divisor),
    .signed_ope(signed_ope),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero),
    .overflow(overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present operands for one edge, then scramble the inputs to prove they were latched
  task automatic start_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sg);
    @(negedge clk);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    dividend   = a;
    divisor    = b;
    signed_ope = sg;
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    dividend   = 32'hDEAD_BEEF;
    divisor    = 32'h0000_0003;
    signed_ope = ~sg;
  endtask

  // Edges after the accepting edge until out_valid; bounded
  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sg,
                     input logic [31:0] eq, input logic [31:0] er, input logic edz, input logic eov,
                     input int elat);
    int n;
    start_op(tag, a, b, sg);
    wait_done(n);
    check({tag, "_lat"}, n, elat);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, edz});
    check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, eov});
    consume();
    check({tag, "_consumed"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    nrst       = 1'b0;
    in_valid   = 1'b0;
    dividend   = '0;
    divisor    = '0;
    signed_ope = 1'b0;
    flush      = 1'b0;
    out_ready  = 1'b0;

    // Reset state, before any clock edge
    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    #10;
    nrst = 1'b1;

    // Normal latency ITER+1 edges after accept; early-outs finish on the accepting edge
    run("u100_7",   32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 1'b0, ITER + 1);
    run("s-7_2",    32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 1'b0, ITER + 1);
    run("s7_-2",    32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0, 1'b0, ITER + 1);
    run("s-8_2",    32'hFFFF_FFF8,  32'd2,          1'b1, 32'hFFFF_FFFC,  32'd0,          1'b0, 1'b0, ITER + 1);
    run("s-100_7",  32'hFFFF_FF9C,  32'd7,          1'b1, 32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, 1'b0, ITER + 1);
    run("u5_0",     32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          1'b1, 1'b0, 0);
    run("s5_0",     32'd5,          32'd0,          1'b1, 32'hFFFF_FFFF,  32'd5,          1'b1, 1'b0, 0);
    run("s_min_m1", 32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0, 1'b1, 0);
    run("u_min_m1", 32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  1'b0, 1'b0, ITER + 1);

    // Back-pressure in DONE: results hold, new requests ignored
    start_op("hold", 32'd100, 32'd7, 1'b0);
    wait_done(lat);
    check("hold_lat", lat, ITER + 1);
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 32'd9;
    divisor  = 32'd0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("hold_q", quotient, 32'd14);
      check("hold_r", remainder, 32'd2);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
    end
    check("hold_flags", {30'd0, div_by_zero, overflow}, 32'd0);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    check("release_out_valid", {31'd0, out_valid}, 32'd0);

    // Flush during BUSY discards the operation
    start_op("flush_busy", 32'd100, 32'd7, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (ITER + 4) @(posedge clk);
    #1;
    check("flush_no_result", {31'd0, out_valid}, 32'd0);
    check("flush_q_kept", quotient, 32'd14);

    // Flush together with in_valid in IDLE must not accept (a divide by zero would finish at once)
    @(negedge clk);
    in_valid = 1'b1;
    flush    = 1'b1;
    dividend = 32'd5;
    divisor  = 32'd0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush_idle_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_idle_in_ready", {31'd0, in_ready}, 32'd1);

    // Asynchronous reset mid-BUSY
    start_op("rst_busy", 32'd100, 32'd7, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    nrst = 1'b0;
    #1;
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_q", quotient, 32'd0);
    check("arst_r", remainder, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    run("u_ffff_16", 32'hFFFF_FFFF, 32'd16, 1'b0, 32'h0FFF_FFFF, 32'd15, 1'b0, 1'b0, ITER + 1);

    // Flush coincident with out_ready in DONE: consumed once, no repeat
    start_op("flush_done", 32'd5, 32'd0, 1'b1);
    wait_done(lat);
    check("flush_done_lat", lat, 0);
    @(negedge clk);
    flush     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    out_ready = 1'b0;
    check("flush_done_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_done_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    check("flush_done_no_dup", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
